alu_rr_sched: RTL and testbench
===============================

// Module: alu_rr_sched
// PURPOSE
// - Shares one alu_16bit instance (16-bit bit-sliced ALU; a, b, cin, m, s[3:0] -> f, cout)
//   between two requesters, for example the datapath and a test/debug port.
// - Arbitrates round-robin, latches the winner's operands and sequences the ALU evaluation.
// - Returns the result with its requester ID over a valid/ready response channel.
// - Sits between the two operand sources and the result consumer.
// PARAMETERS
// - WIDTH  16  datapath width; must be 16 (alu_16bit width); elaboration error otherwise
// - FAIR   1   1 = round-robin between req0/req1; 0 = fixed priority, req0 wins
// PORTS
// - clk         in   1      single clock; all state updates on posedge
// - rst         in   1      synchronous, active-high reset
// - req0_valid  in   1      requester 0 has an operation
// - req0_ready  out  1      requester 0 operation accepted this cycle
// - req0_a      in   WIDTH  operand A
// - req0_b      in   WIDTH  operand B
// - req0_s      in   4      ALU function select
// - req0_m      in   1      mode: 1 = logic, 0 = arithmetic
// - req0_cin    in   1      carry in
// - req1_*      same as req0_* for requester 1
// - rsp_valid   out  1      result available
// - rsp_ready   in   1      consumer accepts result
// - rsp_id      out  1      ID of the requester that issued the result
// - rsp_f       out  WIDTH  ALU F output, registered
// - rsp_cout    out  1      ALU carry out, registered
// BEHAVIOUR
// - Reset is synchronous and active-high; all of the following hold in the cycle after rst=1:
//   state=IDLE, rsp_valid=0, rsp_id=0, rsp_f=0, rsp_cout=0, last_grant=1, operand regs=0.
// - FSM: IDLE -> EXEC -> RESP -> IDLE. A new operation is accepted only in IDLE.
// - IDLE:
//   - The grant is combinational.
//   - If exactly one reqN_valid=1, grant N.
//   - If both are valid and FAIR=1, grant !last_grant. If FAIR=0, grant 0.
//   - reqN_ready=1 only for the granted N, and only in IDLE.
//   - Handshake (valid & ready): latch a/b/s/m/cin and id, set last_grant=N, go to EXEC.
// - EXEC: the ALU is driven from the latched operands only. At the clock edge f/cout are
//   captured into rsp_f/rsp_cout, rsp_valid is set to 1, and the FSM goes to RESP.
// - RESP: rsp_valid, rsp_id, rsp_f and rsp_cout hold stable until rsp_valid & rsp_ready.
//   On that handshake rsp_valid=0 and the FSM goes to IDLE.
// - Latency: request handshake at cycle T -> rsp_valid=1 at T+2.
//   Peak throughput with rsp_ready tied high is 1 operation per 3 cycles.
// - Requesters must keep valid and payload stable until ready. Withdrawing valid early is
//   legal; the request is simply not taken.
// - Both ready outputs are 0 in EXEC and RESP. They are never 1 in the same cycle.
// - Latched operands are frozen outside IDLE, so changes on req* during EXEC/RESP have no effect.
// - rst during EXEC or RESP: the in-flight operation is discarded, no response is issued,
//   and the block returns to the reset state.
// - No overflow or width handling beyond what alu_16bit does; cout is passed through unchanged.
// STRUCTURE
// - Shared package alu_pkg holds:
//   - state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2; 2'd3 returns to IDLE.
//   - named select constants, e.g. S_XOR=4'b0110 and S_AND=4'b1011 (logic, m=1).
//   - ALU_W=16.
// - One sub-module: the existing alu_16bit, instantiated once, ports wired from the operand regs.
// - The arbiter, FSM and response registers are inline in alu_rr_sched.
// TESTING
// 1. Reset, then req0 only: a=16'h0002, b=16'h0001, s=0110, m=1.
//    Expect req0_ready=1 at T, rsp_valid=1 at T+2, rsp_id=0, rsp_f=16'h0003.
// 2. Both valid every cycle, rsp_ready=1, FAIR=1.
//    Expect grants 0,1,0,1 and rsp_id 0,1,0,1. Repeat with FAIR=0: all grants to 0.
// 3. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
//    Expect rsp_f/rsp_id stable, both ready outputs 0, and no second grant until rsp_ready=1.
// 4. req1 only: a=16'h00F0, b=16'h0FF0, s=1011, m=1.
//    Expect rsp_f=16'h00F0, rsp_id=1. Change req1 operands during EXEC: response unchanged.
// 5. Assert rst for 1 cycle during EXEC.
//    Expect no rsp_valid, all outputs 0, and the next simultaneous request granted to req0.
// 6. Arithmetic sweep: random a/b/cin, m=0, all 16 values of s.
//    Expect rsp_f/rsp_cout to equal a standalone alu_16bit reference driven with the same inputs.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU scheduler slice:
//   - ALU_W      : width of the shared alu_16bit datapath
//   - state_t    : scheduler FSM encoding (2'd3 is unused and recovers to IDLE)
//   - S_*        : named ALU function selects
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Logic-mode selects (m = 1)
  localparam logic [3:0] S_XOR = 4'b0110;
  localparam logic [3:0] S_AND = 4'b1011;
  localparam logic [3:0] S_OR  = 4'b1110;
  localparam logic [3:0] S_PASSA = 4'b1111;

  // Arithmetic-mode selects (m = 0)
  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_SUB = 4'b0110;

endpackage : alu_pkg

// File: rtl/alu_16bit.sv
// -----------------------------------------------------------------------------
// alu_16bit
// 16-bit bit-sliced ALU with the classic '181 function set (active-high data).
// Ports:
//   a, b  in  16  operands
//   cin   in  1   carry in (active high, adds 1 in arithmetic mode)
//   m     in  1   1 = logic, 0 = arithmetic
//   s     in  4   function select
//   f     out 16  result
//   cout  out 1   carry out of the arithmetic sum (0 in logic mode)
// -----------------------------------------------------------------------------
module alu_16bit
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             cin,
  input  logic             m,
  input  logic [3:0]       s,
  output logic [ALU_W-1:0] f,
  output logic             cout
);

  logic [ALU_W-1:0] x_s;
  logic [ALU_W-1:0] y_s;
  logic [ALU_W:0]   sum_s;

  // Per-bit slice terms: every arithmetic function is x + y + cin, and the
  // logic function is the carry-free version ~(x ^ y) of the same terms.
  always_comb begin
    x_s   = a | (b & {ALU_W{s[0]}}) | (~b & {ALU_W{s[1]}});
    y_s   = (a & ~b & {ALU_W{s[2]}}) | (a & b & {ALU_W{s[3]}});
    sum_s = {1'b0, x_s} + {1'b0, y_s} + {{ALU_W{1'b0}}, cin};
    if (m) begin
      f    = ~(x_s ^ y_s);
      cout = 1'b0;
    end else begin
      f    = sum_s[ALU_W-1:0];
      cout = sum_s[ALU_W];
    end
  end

endmodule : alu_16bit

// File: rtl/alu_rr_sched.sv
// -----------------------------------------------------------------------------
// alu_rr_sched
// Shares one alu_16bit between two requesters. Arbitrates (round-robin or
// fixed priority), latches the winner's operands, evaluates them in EXEC and
// returns the registered result plus requester ID on a valid/ready channel.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid / reqN_ready       request handshake, N = 0,1
//   reqN_a, reqN_b                operands (WIDTH)
//   reqN_s, reqN_m, reqN_cin      select, mode, carry in
//   rsp_valid / rsp_ready         response handshake
//   rsp_id, rsp_f, rsp_cout       requester ID, ALU result, carry out
// -----------------------------------------------------------------------------
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter bit FAIR  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_s,
  input  logic             req0_m,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_s,
  input  logic             req1_m,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_cout
);

  if (WIDTH != ALU_W) begin : g_width_chk
    $error("alu_rr_sched: WIDTH must equal ALU_W (%0d)", ALU_W);
  end

  state_t           state_r;
  logic             last_grant_r;
  logic             id_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       s_r;
  logic             m_r;
  logic             cin_r;

  logic             grant_valid_s;
  logic             grant_id_s;
  logic [WIDTH-1:0] alu_f_s;
  logic             alu_cout_s;

  // Combinational grant; only IDLE can accept, so ready is forced low elsewhere.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (state_r == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid_s = 1'b1;
        // Round-robin hands the tie to whoever did not win last time.
        grant_id_s    = (FAIR != 1'b0) ? ~last_grant_r : 1'b0;
      end else if (req0_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b0;
      end else if (req1_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
      end
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  assign req0_ready = grant_valid_s & ~grant_id_s;
  assign req1_ready = grant_valid_s &  grant_id_s;

  // Scheduler FSM: operand latch, result capture and response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      id_r         <= 1'b0;
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      s_r          <= 4'd0;
      m_r          <= 1'b0;
      cin_r        <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_f        <= {WIDTH{1'b0}};
      rsp_cout     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // A grant implies the matching valid, so a grant is a handshake.
          if (grant_valid_s) begin
            if (grant_id_s) begin
              a_r   <= req1_a;
              b_r   <= req1_b;
              s_r   <= req1_s;
              m_r   <= req1_m;
              cin_r <= req1_cin;
            end else begin
              a_r   <= req0_a;
              b_r   <= req0_b;
              s_r   <= req0_s;
              m_r   <= req0_m;
              cin_r <= req0_cin;
            end
            id_r         <= grant_id_s;
            last_grant_r <= grant_id_s;
            state_r      <= EXEC;
          end
        end
        EXEC: begin
          rsp_f     <= alu_f_s;
          rsp_cout  <= alu_cout_s;
          rsp_id    <= id_r;
          rsp_valid <= 1'b1;
          state_r   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // The ALU only ever sees the latched operands, so req* activity outside
  // IDLE cannot disturb an in-flight evaluation.
  alu_16bit u_alu (
    .a    (a_r),
    .b    (b_r),
    .cin  (cin_r),
    .m    (m_r),
    .s    (s_r),
    .f    (alu_f_s),
    .cout (alu_cout_s)
  );

endmodule : alu_rr_sched

// File: tb/tb_alu_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_sched
// Directed bench for alu_rr_sched. A round-robin instance (dut) and a fixed
// priority instance (dut_fp) share clock, reset and all inputs. Inputs change
// just after the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_alu_rr_sched;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_s, req1_s;
  logic        req0_m, req0_cin, req1_m, req1_cin;
  logic        rsp_ready;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout;
  logic [15:0] rsp_f;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_cout;
  logic [15:0] fp_rsp_f;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_rr_sched #(.WIDTH(16), .FAIR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_s(req0_s), .req0_m(req0_m), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_s(req1_s), .req1_m(req1_m), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_f(rsp_f), .rsp_cout(rsp_cout)
  );

  alu_rr_sched #(.WIDTH(16), .FAIR(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_s(req0_s), .req0_m(req0_m), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_s(req1_s), .req1_m(req1_m), .req1_cin(req1_cin),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_f(fp_rsp_f), .rsp_cout(fp_rsp_cout)
  );

  // Reference '181 function table (active-high data). Arithmetic results are
  // written as the two addends the datasheet names, summed with cin.
  function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic m, input logic [3:0] s);
    logic [15:0] l;
    logic [16:0] p, q;
    l = 16'h0000; p = 17'h0; q = 17'h0;
    if (m) begin
      case (s)
        4'h0: l = ~a;          4'h1: l = ~(a | b);
        4'h2: l = ~a & b;      4'h3: l = 16'h0000;
        4'h4: l = ~(a & b);    4'h5: l = ~b;
        4'h6: l = a ^ b;       4'h7: l = a & ~b;
        4'h8: l = ~a | b;      4'h9: l = ~(a ^ b);
        4'hA: l = b;           4'hB: l = a & b;
        4'hC: l = 16'hFFFF;    4'hD: l = a | ~b;
        4'hE: l = a | b;       default: l = a;
      endcase
      return {1'b0, l};
    end
    case (s)
      4'h0: begin p = {1'b0, a};        q = 17'h0; end              // A
      4'h1: begin p = {1'b0, a | b};    q = 17'h0; end              // A or B
      4'h2: begin p = {1'b0, a | ~b};   q = 17'h0; end              // A or /B
      4'h3: begin p = 17'h0FFFF;        q = 17'h0; end              // minus 1
      4'h4: begin p = {1'b0, a};        q = {1'b0, a & ~b}; end     // A plus A/B
      4'h5: begin p = {1'b0, a | b};    q = {1'b0, a & ~b}; end
      4'h6: begin p = {1'b0, a};        q = {1'b0, ~b}; end         // A minus B minus 1
      4'h7: begin p = 17'h0FFFF;        q = {1'b0, a & ~b}; end     // A/B minus 1
      4'h8: begin p = {1'b0, a};        q = {1'b0, a & b}; end      // A plus AB
      4'h9: begin p = {1'b0, a};        q = {1'b0, b}; end          // A plus B
      4'hA: begin p = {1'b0, a | ~b};   q = {1'b0, a & b}; end
      4'hB: begin p = 17'h0FFFF;        q = {1'b0, a & b}; end      // AB minus 1
      4'hC: begin p = {1'b0, a};        q = {1'b0, a}; end          // A plus A
      4'hD: begin p = {1'b0, a | b};    q = {1'b0, a}; end
      4'hE: begin p = {1'b0, a | ~b};   q = {1'b0, a}; end
      default: begin p = 17'h0FFFF;     q = {1'b0, a}; end          // A minus 1
    endcase
    return p + q + {16'h0, cin};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] s, input logic m, input logic cin);
    req0_valid = v; req0_a = a; req0_b = b; req0_s = s; req0_m = m; req0_cin = cin;
  endtask

  task automatic set1(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] s, input logic m, input logic cin);
    req1_valid = v; req1_a = a; req1_b = b; req1_s = s; req1_m = m; req1_cin = cin;
  endtask

  // One req0 operation from an IDLE falling edge; ends on the next IDLE falling edge.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s, input logic m, input logic cin);
    logic [16:0] exp;
    exp = ref_alu(a, b, cin, m, s);
    @(negedge clk); set0(1'b1, a, b, s, m, cin); #1;
    chk({tag, "_ready"}, req0_ready, 1'b1);
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk); #1;
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_f"}, rsp_f, exp[15:0]);
    chk({tag, "_cout"}, rsp_cout, exp[16]);
  endtask

  initial begin
    logic        exp_id;
    logic [15:0] ra, rb;
    logic        rc;

    rst = 1'b1; rsp_ready = 1'b1;
    set0(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    set1(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_id", rsp_id, 1'b0);
    chk("rst_f", rsp_f, 16'h0000);
    chk("rst_cout", rsp_cout, 1'b0);
    chk("rst_fp_valid", fp_rsp_valid, 1'b0);

    // 1. req0 only, XOR
    @(negedge clk); set0(1'b1, 16'h0002, 16'h0001, S_XOR, 1'b1, 1'b0); #1;
    chk("t1_ready0", req0_ready, 1'b1);
    chk("t1_ready1", req1_ready, 1'b0);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk("t1_exec_valid", rsp_valid, 1'b0);
    @(negedge clk); #1;
    chk("t1_valid", rsp_valid, 1'b1);
    chk("t1_id", rsp_id, 1'b0);
    chk("t1_f", rsp_f, 16'h0003);
    @(negedge clk); #1;
    chk("t1_drop", rsp_valid, 1'b0);

    // 2. both valid every cycle; fresh reset so the first tie goes to req0
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    set0(1'b1, 16'h1111, 16'h0101, S_XOR, 1'b1, 1'b0);
    set1(1'b1, 16'hAAAA, 16'h00FF, S_AND, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 1);
      #1;
      chk("t2_ready0", req0_ready, !exp_id);
      chk("t2_ready1", req1_ready, exp_id);
      chk("t2_fp_ready0", fp_req0_ready, 1'b1);
      chk("t2_fp_ready1", fp_req1_ready, 1'b0);
      @(negedge clk); @(negedge clk); #1;
      chk("t2_valid", rsp_valid, 1'b1);
      chk("t2_id", rsp_id, exp_id);
      chk("t2_f", rsp_f, exp_id ? 16'h00AA : 16'h1010);
      chk("t2_fp_id", fp_rsp_id, 1'b0);
      chk("t2_fp_f", fp_rsp_f, 16'h1010);
      @(negedge clk);
    end

    // 3. backpressure: last grant was 1, so req0 wins this tie
    rsp_ready = 1'b0; #1;
    chk("t3_ready0", req0_ready, 1'b1);
    @(negedge clk); @(negedge clk); #1;
    chk("t3_valid", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t3_hold_valid", rsp_valid, 1'b1);
      chk("t3_hold_f", rsp_f, 16'h1010);
      chk("t3_hold_id", rsp_id, 1'b0);
      chk("t3_hold_ready0", req0_ready, 1'b0);
      chk("t3_hold_ready1", req1_ready, 1'b0);
    end
    @(negedge clk); rsp_ready = 1'b1; #1;
    chk("t3_rel_valid", rsp_valid, 1'b1);
    @(negedge clk); #1;
    chk("t3_next_ready1", req1_ready, 1'b1);
    chk("t3_next_ready0", req0_ready, 1'b0);
    chk("t3_next_valid", rsp_valid, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // 4. req1 only, AND; operands scribbled during EXEC
    @(negedge clk); set1(1'b1, 16'h00F0, 16'h0FF0, S_AND, 1'b1, 1'b0); #1;
    chk("t4_ready1", req1_ready, 1'b1);
    chk("t4_ready0", req0_ready, 1'b0);
    @(negedge clk); set1(1'b1, 16'hFFFF, 16'hFFFF, 4'h0, 1'b0, 1'b1); #1;
    chk("t4_exec_ready1", req1_ready, 1'b0);
    @(negedge clk); #1;
    chk("t4_valid", rsp_valid, 1'b1);
    chk("t4_id", rsp_id, 1'b1);
    chk("t4_f", rsp_f, 16'h00F0);
    chk("t4_cout", rsp_cout, 1'b0);
    req1_valid = 1'b0;
    @(negedge clk); #1;
    chk("t4_drop", rsp_valid, 1'b0);

    // 5. reset during EXEC of a req0 op
    @(negedge clk); set0(1'b1, 16'h0002, 16'h0001, S_XOR, 1'b1, 1'b0); #1;
    chk("t5_ready0", req0_ready, 1'b1);
    @(negedge clk); req0_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("t5_valid", rsp_valid, 1'b0);
    chk("t5_f", rsp_f, 16'h0000);
    chk("t5_id", rsp_id, 1'b0);
    chk("t5_cout", rsp_cout, 1'b0);
    chk("t5_ready0_idle", req0_ready, 1'b0);
    @(negedge clk); #1;
    chk("t5_no_rsp", rsp_valid, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    chk("t5_tie_ready0", req0_ready, 1'b1);
    chk("t5_tie_ready1", req1_ready, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // 6. arithmetic: directed carry cases, then a random sweep over s
    do_op("t6_add_carry", 16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b0);   // 0000, cout 1
    chk("t6_add_carry_hand", {rsp_cout, rsp_f}, 17'h10000);
    do_op("t6_sub", 16'h0005, 16'h0003, S_SUB, 1'b0, 1'b1);         // 5-3 = 0002, cout 1
    chk("t6_sub_hand", {rsp_cout, rsp_f}, 17'h10002);
    for (int s = 0; s < 16; s++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      do_op("t6_sweep", ra, rb, 4'(s), 1'b0, rc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_alu_rr_sched
